audio_in_capture: RTL and testbench

Capture block for the codec's microphone path. It drains left/right samples from the Audio_Controller input FIFO using its `audio_in_available` / `read_audio_in` handshake. It mixes each stereo pair to one signed mono sample, optionally decimates, and stores the result in an on-chip buffer. On command it streams the buffer back out over a valid/ready port, which the top level sums into the `audio_out` mix alongside the note generators.

---
 rtl/audio_in_capture.sv | 215 +++++++++++++++++++++
 tb/tb_audio_in_capture.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_in_capture.sv
// audio_in_capture
// ----------------
// Microphone capture path for the codec. Drains stereo pairs from the
// Audio_Controller input FIFO, mixes each pair to one signed mono sample,
// optionally keeps only one of every DECIM pops, and stores the result in an
// on-chip buffer. On command the buffer is streamed back out over a
// valid/ready port for the top-level audio_out mix.
//
// Optional feature: define AUDIO_CAPTURE_PEAK_EN to track the largest stored
// |mono| in peak_level. Without it peak_level is tied to 0.
//
// Ports:
//   clock, resetn             system clock, asynchronous active-low reset
//   start_record/stop_record  one-cycle command pulses for capture
//   start_play                one-cycle pulse; stream the captured buffer
//   audio_in_available        controller FIFO holds a sample pair
//   left/right_channel_audio_in  signed samples, valid while available
//   read_audio_in             pop strobe to the controller
//   clear_audio_in_memory     flush strobe to the controller
//   out_valid/out_ready/out_sample  playback stream
//   busy                      not idle
//   done                      one-cycle pulse at the end of a record/play pass
//   sample_count              samples stored by the last capture
//   peak_level                largest stored |mono| (optional feature)
module audio_in_capture #(
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = 12,
    parameter int DECIM  = 1
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               start_record,
    input  logic               stop_record,
    input  logic               start_play,
    input  logic               audio_in_available,
    input  logic signed [31:0] left_channel_audio_in,
    input  logic signed [31:0] right_channel_audio_in,
    output logic               read_audio_in,
    output logic               clear_audio_in_memory,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [31:0] out_sample,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W:0]    sample_count,
    output logic [30:0]        peak_level
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RECORD,
        PLAY_FETCH,
        PLAY_OUT
    } state_t;

    localparam logic [7:0]        DECIM_LAST = 8'(DECIM - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   COUNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [ADDR_W:0]    sample_count_q, sample_count_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic [7:0]         decim_cnt_q, decim_cnt_d;
    logic               done_q, done_d;
    logic               store;
    logic signed [31:0] mono;
    logic signed [31:0] mem [DEPTH];
    logic signed [31:0] rd_data_q;

    // Halving each channel before the add keeps the sum inside 32 bits.
    assign mono = (left_channel_audio_in >>> 1) + (right_channel_audio_in >>> 1);

    // Next-state and command decode. start_record is applied last so it
    // overrides whatever the current state would otherwise do.
    always_comb begin
        state_d               = state_q;
        sample_count_d        = sample_count_q;
        rd_addr_d             = rd_addr_q;
        decim_cnt_d           = decim_cnt_q;
        done_d                = 1'b0;
        store                 = 1'b0;
        read_audio_in         = 1'b0;
        clear_audio_in_memory = 1'b0;
        out_valid             = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_play && sample_count_q != '0) begin
                    state_d   = PLAY_FETCH;
                    rd_addr_d = '0;
                end
            end
            CLEAR: begin
                clear_audio_in_memory = 1'b1;
                state_d               = RECORD;
            end
            RECORD: begin
                // Every pair is popped; decimation only decides what is kept.
                read_audio_in = audio_in_available;
                if (audio_in_available) begin
                    store       = (decim_cnt_q == 8'd0);
                    decim_cnt_d = (decim_cnt_q == DECIM_LAST) ? 8'd0 : decim_cnt_q + 8'd1;
                end
                if (store) begin
                    sample_count_d = sample_count_q + COUNT_ONE;
                end
                // Leave on the write that fills the buffer so no further pop occurs.
                if ((store && sample_count_q[ADDR_W-1:0] == LAST_ADDR) || stop_record) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            PLAY_FETCH: begin
                state_d = PLAY_OUT;
            end
            PLAY_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if ({1'b0, rd_addr_q} == sample_count_q - COUNT_ONE) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        rd_addr_d = rd_addr_q + ADDR_ONE;
                        state_d   = PLAY_FETCH;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (start_record) begin
            state_d        = CLEAR;
            sample_count_d = '0;
            decim_cnt_d    = 8'd0;
            done_d         = 1'b0;
            store          = 1'b0;
        end
    end

    // Control registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q        <= IDLE;
            sample_count_q <= '0;
            rd_addr_q      <= '0;
            decim_cnt_q    <= 8'd0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            sample_count_q <= sample_count_d;
            rd_addr_q      <= rd_addr_d;
            decim_cnt_q    <= decim_cnt_d;
            done_q         <= done_d;
        end
    end

    // Sample buffer: written during capture, read one cycle ahead of PLAY_OUT.
    // The read register only loads in PLAY_FETCH, which keeps out_sample
    // stable while the consumer stalls.
    always_ff @(posedge clock) begin
        if (store) begin
            mem[sample_count_q[ADDR_W-1:0]] <= mono;
        end
        if (state_q == PLAY_FETCH) begin
            rd_data_q <= mem[rd_addr_q];
        end
    end

    assign out_sample   = (state_q == PLAY_OUT) ? rd_data_q : '0;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign sample_count = sample_count_q;

`ifdef AUDIO_CAPTURE_PEAK_EN
    logic [30:0] peak_q, peak_d;
    logic [31:0] mono_neg;
    logic [30:0] mono_abs;

    assign mono_neg = -mono;

    // The most negative mix has no positive twin in 31 bits, so it saturates.
    always_comb begin
        if (mono == 32'sh8000_0000) begin
            mono_abs = 31'h7FFF_FFFF;
        end else if (mono[31]) begin
            mono_abs = mono_neg[30:0];
        end else begin
            mono_abs = mono[30:0];
        end
        peak_d = peak_q;
        if (start_record) begin
            peak_d = '0;
        end else if (store && mono_abs > peak_q) begin
            peak_d = mono_abs;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak_level = peak_q;
`else
    assign peak_level = '0;
`endif

endmodule

// File: tb/tb_audio_in_capture.sv
// Self-checking bench for audio_in_capture. A controller model feeds stereo
// pairs through the available/read handshake and logs every pair popped; the
// expected buffer is derived from those pops with the mix/decimation rules.
// Playback expectations are queued when start_play is issued and a monitor
// compares each handshake against the queue.
`timescale 1ns/1ps
module tb_audio_in_capture;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;
    localparam int DECIM  = 3;

    logic               clock = 1'b0;
    logic               resetn;
    logic               start_record;
    logic               stop_record;
    logic               start_play;
    logic               audio_in_available;
    logic signed [31:0] left_channel_audio_in;
    logic signed [31:0] right_channel_audio_in;
    logic               read_audio_in;
    logic               clear_audio_in_memory;
    logic               out_valid;
    logic               out_ready;
    logic signed [31:0] out_sample;
    logic               busy;
    logic               done;
    logic [ADDR_W:0]    sample_count;
    logic [30:0]        peak_level;

    int checks = 0;
    int errors = 0;

    logic signed [31:0] fifo_l[$];
    logic signed [31:0] fifo_r[$];
    logic signed [31:0] popped_l[$];
    logic signed [31:0] popped_r[$];
    logic signed [31:0] model_samples[$];
    logic signed [31:0] exp_play[$];
    longint             exp_peak;
    int                 popped_base;
    int                 pop_cnt  = 0;
    int                 hs_cnt   = 0;
    int                 done_cnt = 0;
    bit                 gap_en   = 1'b0;
    bit                 pop_now;
    bit                 pop_avail;
    int                 ready_mode = 0;

    audio_in_capture #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DECIM(DECIM)) u_dut (
        .clock                  (clock),
        .resetn                 (resetn),
        .start_record           (start_record),
        .stop_record            (stop_record),
        .start_play             (start_play),
        .audio_in_available     (audio_in_available),
        .left_channel_audio_in  (left_channel_audio_in),
        .right_channel_audio_in (right_channel_audio_in),
        .read_audio_in          (read_audio_in),
        .clear_audio_in_memory  (clear_audio_in_memory),
        .out_valid              (out_valid),
        .out_ready              (out_ready),
        .out_sample             (out_sample),
        .busy                   (busy),
        .done                   (done),
        .sample_count           (sample_count),
        .peak_level             (peak_level)
    );

    always #5 clock = ~clock;

    // Compares one observed value against the bench's expectation.
    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Holds the given command pulses for one clock, then releases them.
    task automatic applyStimulus(input bit rec, input bit stop, input bit play);
        start_record = rec;
        stop_record  = stop;
        start_play   = play;
        @(negedge clock);
        start_record = 1'b0;
        stop_record  = 1'b0;
        start_play   = 1'b0;
    endtask

    // Mono mix of one stereo pair: each channel floored to half, then summed.
    function automatic logic signed [31:0] mix(input logic signed [31:0] l, input logic signed [31:0] r);
        return (l >>> 1) + (r >>> 1);
    endfunction

    function automatic logic signed [31:0] rand_sample();
        case ($urandom_range(0, 5))
            0:       return 32'sh8000_0000;
            1:       return 32'sh7FFF_FFFF;
            2:       return -32'sd1;
            default: return $signed(32'($urandom()));
        endcase
    endfunction

    // Expected buffer: every DECIM-th pop since the capture began, up to DEPTH.
    task automatic buildExpected();
        longint mag;
        model_samples.delete();
        exp_peak = 0;
        for (int i = popped_base; i < popped_l.size(); i++) begin
            if (((i - popped_base) % DECIM) == 0 && model_samples.size() < DEPTH) begin
                model_samples.push_back(mix(popped_l[i], popped_r[i]));
                mag = longint'(model_samples[model_samples.size() - 1]);
                if (mag < 0) mag = -mag;
                if (mag > 64'sd2147483647) mag = 64'sd2147483647;
                if (mag > exp_peak) exp_peak = mag;
            end
        end
`ifndef AUDIO_CAPTURE_PEAK_EN
        exp_peak = 0;
`endif
    endtask

    task automatic pushPair(input logic signed [31:0] l, input logic signed [31:0] r);
        fifo_l.push_back(l);
        fifo_r.push_back(r);
    endtask

    task automatic startRecord(input bit with_play);
        popped_base = popped_l.size();
        applyStimulus(1'b1, 1'b0, with_play);
        checkOutput("clear_strobe_first", clear_audio_in_memory, 1);
        checkOutput("busy_after_start", busy, 1);
        checkOutput("count_cleared", sample_count, 0);
        checkOutput("peak_cleared", peak_level, 0);
        checkOutput("valid_low_in_clear", out_valid, 0);
        @(negedge clock);
        checkOutput("clear_strobe_second", clear_audio_in_memory, 0);
    endtask

    task automatic waitDone(input string name, input int budget);
        int start_cnt;
        int n;
        start_cnt = done_cnt;
        n = 0;
        while (done_cnt == start_cnt && n < budget) begin
            @(negedge clock);
            #3;
            n++;
        end
        repeat (2) @(negedge clock);
        #3;
        checkOutput(name, done_cnt - start_cnt, 1);
    endtask

    task automatic waitDrained(input int budget);
        int n;
        n = 0;
        while (fifo_l.size() != 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        checkOutput("fifo_drained", fifo_l.size(), 0);
    endtask

    task automatic finishRecordChecks(input string tag);
        buildExpected();
        checkOutput({tag, "_sample_count"}, sample_count, model_samples.size());
        checkOutput({tag, "_peak"}, peak_level, exp_peak);
        checkOutput({tag, "_busy_idle"}, busy, 0);
        checkOutput({tag, "_read_idle"}, read_audio_in, 0);
    endtask

    task automatic playAll(input string tag, input int mode, input int budget);
        int hs_start;
        hs_start = hs_cnt;
        foreach (model_samples[i]) exp_play.push_back(model_samples[i]);
        ready_mode = mode;
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput({tag, "_valid_n1"}, out_valid, 0);
        @(negedge clock);
        checkOutput({tag, "_valid_n2"}, out_valid, 1);
        waitDone({tag, "_done"}, budget);
        checkOutput({tag, "_handshakes"}, hs_cnt - hs_start, model_samples.size());
        checkOutput({tag, "_queue_empty"}, exp_play.size(), 0);
        ready_mode = 0;
    endtask

    // Controller FIFO model: presents the queue head, pops on read_audio_in
    // and flushes on clear_audio_in_memory.
    initial begin
        audio_in_available     = 1'b0;
        left_channel_audio_in  = '0;
        right_channel_audio_in = '0;
        pop_now   = 1'b0;
        pop_avail = 1'b0;
        forever begin
            @(negedge clock);
            if (pop_now) begin
                checkOutput("pop_while_available", pop_avail, 1);
                if (fifo_l.size() > 0) begin
                    popped_l.push_back(fifo_l.pop_front());
                    popped_r.push_back(fifo_r.pop_front());
                    pop_cnt++;
                end
            end
            if (clear_audio_in_memory) begin
                fifo_l.delete();
                fifo_r.delete();
            end
            audio_in_available = (fifo_l.size() > 0) && (!gap_en || $urandom_range(0, 3) != 0);
            if (audio_in_available) begin
                left_channel_audio_in  = fifo_l[0];
                right_channel_audio_in = fifo_r[0];
            end else begin
                left_channel_audio_in  = $signed(32'($urandom()));
                right_channel_audio_in = $signed(32'($urandom()));
            end
            #1;
            pop_now   = read_audio_in;
            pop_avail = audio_in_available;
        end
    end

    // Consumer ready pattern: 0 off, 1 repeating 1,0,1, 2 random, 3 always on.
    initial begin
        int cyc;
        cyc = 0;
        out_ready = 1'b0;
        forever begin
            @(negedge clock);
            cyc++;
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = (cyc % 3) != 1;
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Playback monitor: compares every handshake with the queued expectation
    // and checks out_sample holds while the consumer stalls.
    initial begin
        logic signed [31:0] held;
        bit stalled;
        stalled = 1'b0;
        held = '0;
        forever begin
            @(negedge clock);
            #2;
            if (done) done_cnt++;
            if (out_valid && stalled) checkOutput("out_sample_stable", out_sample, held);
            if (out_valid && out_ready) begin
                hs_cnt++;
                checkOutput("play_expected_pending", exp_play.size() > 0, 1);
                if (exp_play.size() > 0) checkOutput("play_sample", out_sample, exp_play.pop_front());
            end
            stalled = out_valid && !out_ready;
            held = out_sample;
        end
    end

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base;
        int n;
        resetn       = 1'b0;
        start_record = 1'b0;
        stop_record  = 1'b0;
        start_play   = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("rst_read", read_audio_in, 0);
        checkOutput("rst_clear", clear_audio_in_memory, 0);
        checkOutput("rst_valid", out_valid, 0);
        checkOutput("rst_sample", out_sample, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_count", sample_count, 0);
        checkOutput("rst_peak", peak_level, 0);
        resetn = 1'b1;
        @(negedge clock);

        $display("[TB] start_play with empty buffer");
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("empty_play_busy_n1", busy, 0);
        @(negedge clock);
        checkOutput("empty_play_busy_n2", busy, 0);

        $display("[TB] basic capture with availability gaps");
        gap_en = 1'b1;
        startRecord(1'b0);
        base = pop_cnt;
        pushPair(32'sd100, 32'sd300);
        pushPair(rand_sample(), rand_sample());
        pushPair(rand_sample(), rand_sample());
        pushPair(-32'sd8, -32'sd8);
        pushPair(rand_sample(), rand_sample());
        waitDrained(100);
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitDone("basic_rec_done", 20);
        checkOutput("basic_pops", pop_cnt - base, 5);
        finishRecordChecks("basic");

        $display("[TB] playback with ready 1,0,1 and replay");
        playAll("play_101", 1, 100);
        playAll("replay", 3, 100);

        $display("[TB] fill the buffer with continuous availability");
        gap_en = 1'b0;
        startRecord(1'b0);
        base = pop_cnt;
        for (int i = 0; i < DEPTH * DECIM + 10; i++) pushPair(rand_sample(), rand_sample());
        waitDone("full_done", 200);
        checkOutput("full_pops", pop_cnt - base, (DEPTH - 1) * DECIM + 1);
        finishRecordChecks("full");
        checkOutput("full_count_depth", sample_count, DEPTH);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checkOutput("full_still_available", audio_in_available, 1);
            checkOutput("full_no_read", read_audio_in, 0);
        end
        checkOutput("full_pops_frozen", pop_cnt - base, (DEPTH - 1) * DECIM + 1);
        playAll("play_full", 2, 300);

        $display("[TB] stop while pairs are still arriving");
        startRecord(1'b0);
        for (int i = 0; i < 20; i++) pushPair(rand_sample(), rand_sample());
        repeat (3) @(negedge clock);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("rec_play_ignored_valid", out_valid, 0);
        checkOutput("rec_play_ignored_read", read_audio_in, 1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitDone("midstop_done", 20);
        finishRecordChecks("midstop");
        playAll("play_midstop", 2, 200);

        $display("[TB] abort playback with start_record");
        foreach (model_samples[i]) exp_play.push_back(model_samples[i]);
        applyStimulus(1'b0, 1'b0, 1'b1);
        @(negedge clock);
        checkOutput("abort_valid_before", out_valid, 1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("play_stop_ignored_busy", busy, 1);
        startRecord(1'b1);
        exp_play.delete();
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitDone("abort_rec_done", 20);
        finishRecordChecks("abort");
        checkOutput("abort_count_zero", sample_count, 0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("abort_empty_play_n1", busy, 0);
        @(negedge clock);
        checkOutput("abort_empty_play_n2", busy, 0);

        $display("[TB] peak tracking");
        startRecord(1'b0);
        pushPair(32'sd60, 32'sd40);
        pushPair(32'sh7FFF_FFFE, 32'sh7FFF_FFFE);
        pushPair(-32'sd2000000, -32'sd2000000);
        pushPair(-32'sd700, -32'sd700);
        pushPair(32'sd5000, 32'sd5000);
        pushPair(32'sd123, -32'sd9999);
        pushPair(32'sd600, 32'sd0);
        waitDrained(100);
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitDone("peak_done", 20);
        finishRecordChecks("peak");
`ifdef AUDIO_CAPTURE_PEAK_EN
        checkOutput("peak_700", peak_level, 700);
`else
        checkOutput("peak_tied_zero", peak_level, 0);
`endif
        playAll("play_peak", 3, 100);
        startRecord(1'b0);
        pushPair(32'sh8000_0000, 32'sh8000_0000);
        waitDrained(100);
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitDone("sat_done", 20);
        finishRecordChecks("sat");

        $display("[TB] randomized capture/playback rounds");
        for (int r = 0; r < 4; r++) begin
            gap_en = 1'b1;
            startRecord(1'b0);
            base = pop_cnt;
            n = $urandom_range(1, (DEPTH - 1) * DECIM);
            for (int i = 0; i < n; i++) pushPair(rand_sample(), rand_sample());
            waitDrained(400);
            applyStimulus(1'b0, 1'b1, 1'b0);
            waitDone("rand_rec_done", 20);
            checkOutput("rand_pops", pop_cnt - base, n);
            finishRecordChecks("rand");
            playAll("rand_play", 2, 300);
        end

        repeat (3) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
